// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers.
// Used by the transmitter and by the bench-side receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int UART_DATA_BITS = 8;

  function automatic int frame_cycles(input int clks, input int par_en, input int stop_bits);
    return (1 + UART_DATA_BITS + par_en + stop_bits) * clks;
  endfunction

  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose: synchronous FIFO, head word visible on pop_dat while not empty.
// Latency: a pushed word is poppable on the cycle after the push edge.
// Backpressure: full blocks pushes and empty blocks pops; count is occupancy.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_dat,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_dat,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_xmtr.sv
// Purpose: UART transmitter, byte stream in, LSB-first async frames out on txd.
// Latency: byte accepted at edge N into an idle, empty block drives the start bit after edge N+1.
// Backpressure: s_ready drops while the FIFO is full; cts only gates the start of new frames.
module uart_xmtr
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [7:0]                        s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              cts,
  output logic                              txd,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int               CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  uart_tx_state_e   state, state_d;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       sh, sh_d;
  logic             par_bit, par_bit_d;
  logic             stop_idx, stop_idx_d;
  logic             txd_d;
  logic             ready_q;

  logic             push;
  logic             pop;
  logic [7:0]       head_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    count_nxt;
  logic             can_start;
  logic             bit_end;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (s_data),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign s_ready   = ready_q;
  assign push      = s_valid && ready_q && !fifo_full;
  assign can_start = !fifo_empty && cts;
  assign bit_end   = (baud_cnt == CNT_LAST);
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt + 1'b1;
    bit_idx_d  = bit_idx;
    sh_d       = sh;
    par_bit_d  = par_bit;
    stop_idx_d = stop_idx;
    pop        = 1'b0;

    unique case (state)
      IDLE: begin
        baud_cnt_d = '0;
        if (can_start) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          sh_d       = {1'b0, sh[7:1]};
          bit_idx_d  = bit_idx + 1'b1;
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (stop_idx != LAST_STOP) begin
            stop_idx_d = 1'b1;
          end else if (can_start) begin
            // Back-to-back frames: next start bit follows the last stop cycle directly.
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      sh_d      = head_dat;
      par_bit_d = calc_parity(head_dat, PAR_ODD);
    end
  end

  // txd is registered from the next-state view so it changes on the same edge as the FSM.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[0];
      PARITY:  txd_d = par_bit_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      par_bit  <= 1'b0;
      stop_idx <= 1'b0;
      txd      <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      sh       <= sh_d;
      par_bit  <= par_bit_d;
      stop_idx <= stop_idx_d;
      txd      <= txd_d;
      ready_q  <= (count_nxt < CW'(FIFO_DEPTH));
    end
  end

endmodule
